// File: rtl/preempt_sequencer_if.sv
// preempt_sequencer_if: emergency request, controller codes and lamp drive bundled between controller side and sequencer.
interface preempt_sequencer_if;
    logic [3:0] emg_req;
    logic [2:0] ctl_a, ctl_b, ctl_c, ctl_d;
    logic [2:0] lamp_a, lamp_b, lamp_c, lamp_d;
    logic       ctl_hold;
    logic       preempt_active;
    logic [1:0] preempt_dir;

    modport master (
        output emg_req, ctl_a, ctl_b, ctl_c, ctl_d,
        input  lamp_a, lamp_b, lamp_c, lamp_d, ctl_hold, preempt_active, preempt_dir
    );

    modport slave (
        input  emg_req, ctl_a, ctl_b, ctl_c, ctl_d,
        output lamp_a, lamp_b, lamp_c, lamp_d, ctl_hold, preempt_active, preempt_dir
    );
endinterface

// File: rtl/preempt_sequencer.sv
// preempt_sequencer: emergency preemption between traffic controller and lamps A-D, round-robin among requests.
// Optional PREEMPT_TIMEOUT_EN bounds SERVE to MAX_SERVE cycles and masks the timed-out request until it drops.
module preempt_sequencer #(
    parameter int YEL_CYC    = 3,
    parameter int ALLRED_CYC = 2,
    parameter int MIN_HOLD   = 8,
    parameter int CNT_W      = 4
`ifdef PREEMPT_TIMEOUT_EN
    ,
    parameter int MAX_SERVE  = 12
`endif
) (
    input logic clk,
    input logic rst_n,
    preempt_sequencer_if.slave bus
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [CNT_W-1:0] L_YEL_END  = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] L_RED_END  = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] L_HOLD_END = CNT_W'(MIN_HOLD - 1);

    typedef enum logic [2:0] {IDLE, ENTER_Y, ENTER_R, SERVE, EXIT_Y, EXIT_R} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_ptr, w_ptr_nxt, r_dir, w_dir_nxt, w_pick_idle, w_pick_exit;
    logic [2:0]       w_ctl [4];
    logic [2:0]       r_cap [4];
    logic [2:0]       w_cap_nxt [4];
    logic [2:0]       r_lamp [4];
    logic [2:0]       w_lamp_nxt [4];
    logic [3:0]       w_req, w_busy;
    logic             w_tout, r_active, w_yel_done, w_red_done;

    function automatic logic [2:0] legal(input logic [2:0] c);
        return (c == RED || c == YEL || c == GRN) ? c : RED;
    endfunction

    function automatic logic busy(input logic [2:0] c);
        return c == GRN || c == YEL;
    endfunction

    // first set bit at or above base, wrapping D->A
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign w_ctl[0] = bus.ctl_a;
    assign w_ctl[1] = bus.ctl_b;
    assign w_ctl[2] = bus.ctl_c;
    assign w_ctl[3] = bus.ctl_d;

`ifdef PREEMPT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] L_MAX_END = CNT_W'(MAX_SERVE - 1);
    logic [3:0] r_mask;

    assign w_tout = r_state == SERVE && r_timer >= L_MAX_END;
    assign w_req  = bus.emg_req & ~r_mask;

    // a timed-out approach stays masked until its request is sampled low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '0;
        else
            r_mask <= (r_mask & bus.emg_req) | (w_tout ? 4'b0001 << r_dir : 4'b0000);
    end
`else
    assign w_tout = 1'b0;
    assign w_req  = bus.emg_req;
`endif

    assign w_yel_done  = r_timer == L_YEL_END;
    assign w_red_done  = r_timer == L_RED_END;
    assign w_pick_idle = rr_pick(w_req, r_ptr);
    assign w_pick_exit = rr_pick(w_req, r_dir + 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: if (|w_req) begin
                w_dir_nxt   = w_pick_idle;
                w_state_nxt = (w_ctl[w_pick_idle] == GRN) ? SERVE : (|w_busy) ? ENTER_Y : ENTER_R;
            end
            ENTER_Y: w_state_nxt = w_yel_done ? ENTER_R : ENTER_Y;
            ENTER_R: w_state_nxt = w_red_done ? SERVE : ENTER_R;
            SERVE:   w_state_nxt = (w_tout || (!bus.emg_req[r_dir] && r_timer >= L_HOLD_END)) ? EXIT_Y : SERVE;
            EXIT_Y:  w_state_nxt = w_yel_done ? EXIT_R : EXIT_Y;
            EXIT_R: if (w_red_done) begin
                w_ptr_nxt   = r_dir + 2'd1;
                w_dir_nxt   = (|w_req) ? w_pick_exit : r_dir;
                w_state_nxt = (|w_req) ? SERVE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // lamps are decoded from the state being entered so they change on the same edge as the FSM
    for (genvar g = 0; g < 4; g++) begin : g_lamp
        assign w_busy[g]     = busy(w_ctl[g]);
        assign w_cap_nxt[g]  = (r_state == IDLE) ? w_ctl[g] : r_cap[g];
        assign w_lamp_nxt[g] = (w_state_nxt == IDLE)    ? legal(w_ctl[g]) :
                               (w_state_nxt == ENTER_Y) ? (busy(w_cap_nxt[g]) ? YEL : RED) :
                               (w_dir_nxt != 2'(g))     ? RED :
                               (w_state_nxt == SERVE)   ? GRN :
                               (w_state_nxt == EXIT_Y)  ? YEL : RED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_ptr    <= '0;
            r_dir    <= '0;
            r_active <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cap[i]  <= RED;
                r_lamp[i] <= RED;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= (w_state_nxt != r_state) ? '0 : (&r_timer ? r_timer : r_timer + CNT_W'(1));
            r_ptr    <= w_ptr_nxt;
            r_dir    <= w_dir_nxt;
            r_active <= w_state_nxt != IDLE;
            for (int i = 0; i < 4; i++) begin
                r_cap[i]  <= w_cap_nxt[i];
                r_lamp[i] <= w_lamp_nxt[i];
            end
        end
    end

    assign bus.lamp_a         = r_lamp[0];
    assign bus.lamp_b         = r_lamp[1];
    assign bus.lamp_c         = r_lamp[2];
    assign bus.lamp_d         = r_lamp[3];
    assign bus.ctl_hold       = r_active;
    assign bus.preempt_active = r_active;
    assign bus.preempt_dir    = r_dir;
endmodule

// File: doc/preempt_sequencer.md
Name: preempt_sequencer

Overview:
Emergency-vehicle preemption sequencer between the adaptive traffic controller and the four approach lamps (A–D).
- Idle: passes the controller's light codes through to the lamps, registered.
- On an emergency request: freezes the controller, clears conflicting greens through yellow and all-red, and holds green on the requesting approach.
- Then clears back and returns control. Round-robin arbitration among simultaneous requests.

Parameters:
YEL_CYC, 3, yellow clearance length in cycles (≥1)
ALLRED_CYC, 2, all-red clearance length in cycles (≥1)
MIN_HOLD, 8, minimum preempt-green cycles (≥1)
CNT_W, 4, phase timer width; must hold max of the above (and MAX_SERVE if enabled)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
emg_req  in  4  level request per approach, bit0=A … bit3=D
ctl_a, ctl_b, ctl_c, ctl_d  in  3 each  controller light codes
lamp_a, lamp_b, lamp_c, lamp_d  out  3 each  lamp drive codes, registered
ctl_hold  out  1  freeze request to controller (controller keeps its state/timers)
preempt_active  out  1  high in any non-IDLE state
preempt_dir  out  2  index of the approach being served (valid when preempt_active)

Behaviour:
- Light codes are one-hot: 3'b100 red, 3'b010 yellow, 3'b001 green. In IDLE, any non-one-hot ctl code drives that lamp red.
- Reset (async, immediate, including mid-sequence):
  - state IDLE
  - all lamps 3'b100
  - ctl_hold=0, preempt_active=0, preempt_dir=0
  - round-robin pointer=0 (A)
  - timer=0
- All outputs are registered; a ctl change appears on the lamp one cycle later.
- States and transitions:
  - IDLE: lamps follow ctl_x. emg_req is sampled each edge. If any bit is set, grant goes to the first set bit searching upward from the pointer, wrapping D→A, and preempt_dir=grant. Next state:
    - if the granted approach's ctl code is green → SERVE (no clearance);
    - else if any ctl code is green or yellow → ENTER_Y;
    - else → ENTER_R.
  - ENTER_Y: exactly YEL_CYC cycles. Lamps whose captured ctl was green/yellow show yellow; all others red. Then → ENTER_R.
  - ENTER_R: exactly ALLRED_CYC cycles, all lamps red. Then → SERVE.
  - SERVE: lamp[dir]=green, others red. Stays while emg_req[dir]=1 or timer<MIN_HOLD. Exits when the request is low and at least MIN_HOLD cycles have elapsed → EXIT_Y.
  - EXIT_Y: lamp[dir] yellow, others red, for YEL_CYC cycles → EXIT_R.
  - EXIT_R: all red for ALLRED_CYC cycles. At the last cycle the pointer becomes dir+1 (mod 4). If another emg_req bit is set, grant from the new pointer and go → SERVE directly (already all-red); else → IDLE.
- ctl_hold and preempt_active are 1 in every state except IDLE; both drop in the first IDLE cycle.
- Requests on other approaches during ENTER_*/SERVE/EXIT_* are ignored until EXIT_R.
- A request deasserting during ENTER_Y/ENTER_R does not abort the sequence: the approach still gets MIN_HOLD green.
- ctl_x values are captured at the IDLE exit edge. Changes while held are ignored.
- The timer resets on every state entry; the counter never wraps. All state durations are exact.

Optional Feature:
PREEMPT_TIMEOUT_EN
- Defined: adds parameter MAX_SERVE (default 12, must exceed MIN_HOLD). SERVE exits to EXIT_Y after MAX_SERVE cycles even if the request is still high. That approach's request bit is then masked from arbitration until it is seen low for one cycle.
- Undefined: SERVE is unbounded while the request stays high; no mask logic.

Test Plan:
1. Assert rst_n=0 for 2 cycles, then release; hold emg_req=0 and ctl_a=3'b001, others 3'b100 → during reset all lamps=3'b100 and ctl_hold=0. Lamp_a=3'b001 one cycle after release.
2. ctl_b=3'b001, others red; emg_req=4'b0001 for 20 cycles → lamp_b 3'b010 for 3 cycles, then all red for 2 cycles, then lamp_a=3'b001 until the request drops, then lamp_a 3'b010 for 3 cycles and all red for 2. ctl_hold=1 throughout, 0 on return; pointer=1.
3. ctl_a=3'b001; 1-cycle pulse on emg_req[0] → immediate SERVE with no yellow or all-red. lamp_a green for exactly 8 cycles, then 3+2 exit cycles.
4. From reset, emg_req=4'b1010 held → B served first (preempt_dir=1). On request release, after EXIT_R, D is served directly (preempt_dir=3) with no ENTER_Y.
5. rst_n pulsed low during SERVE → lamps all 3'b100 and ctl_hold=0 within the same cycle, without waiting for a clock edge.
6. (PREEMPT_TIMEOUT_EN) emg_req[2] held for 40 cycles → C green for exactly 12 cycles, then exits. C is not re-granted until emg_req[2] is seen low.
